// File: rtl/efuse_trim_shadow.sv
// Shadow register for eFuse trim data: captures autoload segments, CRC-8 checks the
// 256-bit image byte-serially, and drives the trim fabric with an override mux.
module efuse_trim_shadow #(
  parameter int NR = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           efuse_autoload_vld,
  input  logic [NR-1:0]  efuse_autoload_data,
  input  logic           efuse_autoload_done,
  input  logic           rg_trim_override_en,
  input  logic [255:0]   rg_trim_override,
  output logic [255:0]   trim_data,
  output logic           trim_valid,
  output logic           trim_crc_err,
  output logic           trim_load_err,
  output logic           trim_busy,
  output logic [1:0]     dbg_state
);

  localparam int NSEG = 256 / NR;
  localparam int CW   = $clog2(NSEG + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [255:0]    shadow;
  logic [CW-1:0]   seg_cnt;
  logic            ovf;
  logic [4:0]      byte_idx;
  logic [7:0]      crc;
  logic            crc_ok;
  logic            crc_err;
  logic            load_err;
  logic            busy;

  logic            room;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic [CW-1:0]   cnt_eff;
  logic            ovf_eff;
  logic [7:0]      cur_byte;
  logic [7:0]      crc_nxt;

  // Handshake: the controller has no ready; vld and done are single-cycle pulses that
  // are always accepted, and vld may be asserted on every cycle.

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign room = (seg_cnt < CW'(NSEG));

  // Any vld outside LOAD starts a fresh load at segment 0, including an abort of CHECK.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (efuse_autoload_vld) begin
      if (state == LOAD) begin
        wr_en  = room;
        wr_idx = seg_cnt;
      end else begin
        wr_en  = 1'b1;
      end
    end
  end

  // A vld coinciding with done is counted before the count is judged.
  assign cnt_eff  = (efuse_autoload_vld && room) ? seg_cnt + 1'b1 : seg_cnt;
  assign ovf_eff  = ovf | (efuse_autoload_vld & ~room);
  assign cur_byte = shadow[{byte_idx, 3'b000} +: 8];
  assign crc_nxt  = crc8_step(crc, cur_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      seg_cnt  <= '0;
      ovf      <= 1'b0;
      byte_idx <= '0;
      crc      <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      load_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (wr_en && wr_idx == CW'(k)) begin
          shadow[k*NR +: NR] <= efuse_autoload_data;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (efuse_autoload_vld) begin
            state    <= LOAD;
            seg_cnt  <= CW'(1);
            ovf      <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            load_err <= 1'b0;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          if (efuse_autoload_vld) begin
            if (room) seg_cnt <= seg_cnt + 1'b1;
            else      ovf     <= 1'b1;
          end
          if (efuse_autoload_done) begin
            if (cnt_eff == CW'(NSEG) && !ovf_eff) begin
              state    <= CHECK;
              byte_idx <= '0;
              crc      <= '0;
            end else begin
              state    <= DONE;
              load_err <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        CHECK: begin
          if (efuse_autoload_vld) begin
            state    <= LOAD;
            seg_cnt  <= CW'(1);
            ovf      <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            load_err <= 1'b0;
            busy     <= 1'b1;
          end else begin
            crc      <= crc_nxt;
            byte_idx <= byte_idx + 1'b1;
            // Byte 30 is the last payload byte; byte 31 holds the stored CRC.
            if (byte_idx == 5'd30) begin
              state   <= DONE;
              busy    <= 1'b0;
              crc_ok  <= (crc_nxt == shadow[255:248]);
              crc_err <= (crc_nxt != shadow[255:248]);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign trim_data     = rg_trim_override_en ? rg_trim_override : shadow;
  assign trim_valid    = crc_ok | rg_trim_override_en;
  assign trim_crc_err  = crc_err;
  assign trim_load_err = load_err;
  assign trim_busy     = busy;
  assign dbg_state     = state;

endmodule

// File: doc/efuse_trim_shadow.md
# efuse_trim_shadow

- Sits directly downstream of the eFuse controller.
- Captures the NR-bit segments that the controller delivers during autoload or refresh, in order, into a 256-bit shadow image.
- Checks the image with a byte-serial CRC-8.
- Presents the trim image, or a register override, to the analog trim fabric with a qualified valid.

## Interface

Parameters:
- NR, 64 — segment width; legal values 32, 64, 128.
- NSEG, 256/NR — derived segment count; not overridable.

Ports:
- clk  in  1  — system clock.
- rst_n  in  1  — asynchronous active-low reset.
- efuse_autoload_vld  in  1  — one-cycle pulse; efuse_autoload_data holds the next segment.
- efuse_autoload_data  in  NR  — segment data, from the controller's read-data output.
- efuse_autoload_done  in  1  — one-cycle pulse after the last segment.
- rg_trim_override_en  in  1  — select the override image.
- rg_trim_override  in  256  — override image.
- trim_data  out  256  — trim image to the analog fabric.
- trim_valid  out  1  — trim_data is qualified.
- trim_crc_err  out  1  — CRC mismatch on the last load.
- trim_load_err  out  1  — wrong segment count on the last load.
- trim_busy  out  1  — state is LOAD or CHECK.

## Operation

- Shadow image shadow[255:0]:
  - Segment k lands at shadow[k*NR +: NR].
  - Byte b is shadow[8b+7:8b].
  - Bytes 0..30 are payload; byte 31 is the stored CRC.
- CRC-8 parameters: polynomial 0x07, init 0x00, no reflection, no final XOR. Computed over bytes 0..30, byte 0 first.
- States: IDLE, LOAD, CHECK, DONE.
- IDLE / DONE on vld:
  - Write the segment at index 0; seg_cnt=1.
  - Clear trim_valid, trim_crc_err and trim_load_err.
  - Go to LOAD.
  - A refresh re-enters the flow through this path.
- LOAD on vld:
  - If seg_cnt<NSEG: write shadow segment seg_cnt and increment seg_cnt.
  - If seg_cnt==NSEG: drop the segment, set an internal overflow flag, leave seg_cnt unchanged.
- LOAD on done:
  - seg_cnt includes any vld in the same cycle, which is written first.
  - If seg_cnt==NSEG and no overflow: go to CHECK with byte_idx=0, crc=0x00.
  - Otherwise: set trim_load_err and go to DONE; trim_valid stays 0.
- CHECK:
  - One byte per cycle: crc = crc8(crc ^ byte[byte_idx]); byte_idx increments.
  - After byte 30 is processed, compare the result with byte 31:
    - match: trim_valid=1;
    - mismatch: trim_crc_err=1.
  - Then go to DONE.
- CHECK on vld: abort the check, treat the segment as segment 0 (the IDLE/DONE path), go to LOAD.
- done outside LOAD: ignored.
- trim_data:
  - rg_trim_override_en ? rg_trim_override : shadow (combinational mux).
  - Shadow contents are always passed through, even when invalid.
- Effective valid output: trim_valid = crc_ok_reg | rg_trim_override_en.
- trim_crc_err and trim_load_err do not depend on override.

## Timing

- Reset (async assert, sync deassert upstream) sets:
  - state IDLE, shadow = 0, seg_cnt = 0, crc = 0;
  - trim_valid = 0 (unless override is high), trim_crc_err = 0, trim_load_err = 0, trim_busy = 0.
- Reset mid-LOAD or mid-CHECK discards everything; the next vld starts a fresh load.
- A vld sampled at edge E: the segment is visible on trim_data after E.
- done sampled at edge T: CHECK occupies edges T+1..T+31. trim_valid or trim_crc_err is registered at edge T+31, with trim_busy low in the same cycle.
- trim_busy is registered and high from the edge after the first vld to the edge that sets the result.
- Error flags are sticky until the next load starts (first vld) or reset.
- Back-to-back vld on every cycle is supported with no gaps required.
- Override toggles affect trim_data and trim_valid combinationally with zero latency.

## Test plan

- NR=64, four vld pulses all 0x0, then done → after 31 cycles trim_valid=1, trim_crc_err=0, trim_data=0.
- Same load, but segment 3 = 0x0100_0000_0000_0000 (byte 31 = 0x01) → trim_crc_err=1, trim_valid=0.
- Segments 0..2 = 0; segment 3 = 0x0701_0000_0000_0000 (byte 30 = 0x01, byte 31 = 0x07) → trim_valid=1.
- Segment-count errors, each → trim_load_err=1, trim_valid=0:
  - three vld then done;
  - five vld then done.
- vld arriving 10 cycles into CHECK:
  - check aborts, trim_busy stays 1;
  - four new all-zero segments plus done → trim_valid=1 exactly 31 cycles after done.
- Async reset mid-LOAD:
  - all outputs return to reset values immediately;
  - rg_trim_override_en=1 with rg_trim_override=0xA5…A5 → trim_data=0xA5…A5, trim_valid=1 in the same cycle.
